// File: rtl/ex_cpu_pkg.sv
// Shared constants for the ex_cpu accumulator processor: opcodes, register codes, data width.
package ex_cpu_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned REG_W    = 3;

  typedef enum logic [1:0] {
    OP_IN  = 2'b00,
    OP_ADD = 2'b01,
    OP_MOV = 2'b10,
    OP_OUT = 2'b11
  } opcode_t;

  localparam logic [REG_W-1:0] REG_A = 3'd0;
  localparam logic [REG_W-1:0] REG_B = 3'd1;
  localparam logic [REG_W-1:0] REG_C = 3'd2;
  localparam logic [REG_W-1:0] REG_D = 3'd3;
  localparam logic [REG_W-1:0] REG_E = 3'd4;
  localparam logic [REG_W-1:0] REG_F = 3'd5;
  localparam logic [REG_W-1:0] REG_G = 3'd6;
  localparam logic [REG_W-1:0] REG_H = 3'd7;

endpackage

// File: rtl/ex_cpu_regfile.sv
// 8x8 register file: one combinational read port, one synchronous write port,
// plus a dedicated accumulator (A) write/read path.
module ex_cpu_regfile
  import ex_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              a_we,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_q
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (we) begin
        regs[waddr] <= wdata;
      end
      // Accumulator path wins if both ever target A in the same cycle.
      if (a_we) begin
        regs[REG_A] <= a_wdata;
      end
    end
  end

  assign rdata = regs[raddr];
  assign a_q   = regs[REG_A];

endmodule

// File: rtl/ex_cpu.sv
// Single-cycle 8-bit accumulator CPU (IN / ADD / MOV / OUT) with exported decode strobes.
// Build option: define EX_CPU_ADD_SAT_EN to make ADD saturate at 8'hFF instead of wrapping.
module ex_cpu
  import ex_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] Out,
  input  logic [7:0]        instr,
  output logic [DATA_W-1:0] common_line,
  output logic              in_sig,
  output logic              add_sig,
  output logic              mov_sig,
  output logic              out_sig,
  output logic              read_en,
  output logic              write_en,
  output logic              load_a,
  output logic              load_b,
  output logic              sum_sig,
  output logic [REG_W-1:0]  source,
  output logic [REG_W-1:0]  dest
);

  opcode_t           opcode;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] sum;

  assign opcode = opcode_t'(instr[7:6]);

  always_comb begin
    in_sig      = 1'b0;
    add_sig     = 1'b0;
    mov_sig     = 1'b0;
    out_sig     = 1'b0;
    source      = '0;
    dest        = '0;
    common_line = '0;
    if (!rst) begin
      unique case (opcode)
        OP_IN: begin
          in_sig      = 1'b1;
          dest        = instr[5:3];
          common_line = in;
        end
        OP_ADD: begin
          add_sig     = 1'b1;
          source      = instr[2:0];
          common_line = rd_data;
        end
        OP_MOV: begin
          mov_sig     = 1'b1;
          source      = instr[2:0];
          dest        = instr[5:3];
          common_line = rd_data;
        end
        OP_OUT: begin
          out_sig     = 1'b1;
          source      = instr[2:0];
          common_line = rd_data;
        end
        default: ;
      endcase
    end
  end

  assign read_en  = add_sig | mov_sig | out_sig;
  assign write_en = in_sig | mov_sig;
  assign load_a   = add_sig;
  assign load_b   = add_sig;
  assign sum_sig  = add_sig;

`ifdef EX_CPU_ADD_SAT_EN
  logic [DATA_W:0] sum_wide;
  always_comb begin
    sum_wide = {1'b0, a_q} + {1'b0, common_line};
    sum      = sum_wide[DATA_W] ? '1 : sum_wide[DATA_W-1:0];
  end
`else
  always_comb begin
    sum = a_q + common_line;
  end
`endif

  ex_cpu_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (write_en),
    .waddr   (dest),
    .wdata   (common_line),
    .raddr   (instr[2:0]),
    .rdata   (rd_data),
    .a_we    (load_a),
    .a_wdata (sum),
    .a_q     (a_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      Out <= '0;
    end else if (out_sig) begin
      Out <= common_line;
    end
  end

endmodule

// File: tb/tb_ex_cpu.sv
// Bench for ex_cpu: directed program table with hand-computed Out values, then random
// instructions checked against an array-based architectural model.
module tb_ex_cpu;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [7:0] Out;
  logic [7:0] instr;
  logic [7:0] common_line;
  logic       in_sig, add_sig, mov_sig, out_sig;
  logic       read_en, write_en, load_a, load_b, sum_sig;
  logic [2:0] source, dest;

  always #5 clk = ~clk;

  ex_cpu dut (
    .clk         (clk),
    .rst         (rst),
    .in          (din),
    .Out         (Out),
    .instr       (instr),
    .common_line (common_line),
    .in_sig      (in_sig),
    .add_sig     (add_sig),
    .mov_sig     (mov_sig),
    .out_sig     (out_sig),
    .read_en     (read_en),
    .write_en    (write_en),
    .load_a      (load_a),
    .load_b      (load_b),
    .sum_sig     (sum_sig),
    .source      (source),
    .dest        (dest)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural state of the model.
  logic [7:0] m_reg [8];
  logic [7:0] m_out;

  typedef struct {
    logic       rst;
    logic [7:0] instr;
    logic [7:0] din;
    logic       chk;
    logic [7:0] exp_out;
  } vec_t;

  vec_t tbl [$];

`ifdef EX_CPU_ADD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] ins, input logic [7:0] d);
    logic [1:0] op;
    logic [2:0] s, dd;
    logic [8:0] e_dec;
    logic [7:0] e_bus;
    logic [2:0] e_src, e_dst;
    int         total;
    op = ins[7:6];
    dd = ins[5:3];
    s  = ins[2:0];
    @(negedge clk);
    rst   = r;
    instr = ins;
    din   = d;
    #1;
    if (r) begin
      e_dec = '0; e_bus = '0; e_src = '0; e_dst = '0;
    end else begin
      // {in, add, mov, out, read_en, write_en, load_a, load_b, sum_sig}
      case (op)
        2'd0: begin e_dec = 9'b1000_0100_0; e_bus = d;        e_src = 3'd0; e_dst = dd;   end
        2'd1: begin e_dec = 9'b0100_1011_1; e_bus = m_reg[s]; e_src = s;    e_dst = 3'd0; end
        2'd2: begin e_dec = 9'b0010_1100_0; e_bus = m_reg[s]; e_src = s;    e_dst = dd;   end
        default: begin e_dec = 9'b0001_1000_0; e_bus = m_reg[s]; e_src = s; e_dst = 3'd0; end
      endcase
    end
    cmp("decode", {in_sig, add_sig, mov_sig, out_sig, read_en, write_en, load_a, load_b, sum_sig}, e_dec);
    cmp("common_line", common_line, e_bus);
    cmp("source", source, e_src);
    cmp("dest", dest, e_dst);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 8'd0;
      m_out = 8'd0;
    end else begin
      case (op)
        2'd0: m_reg[dd] = d;
        2'd1: begin
          total = int'(m_reg[0]) + int'(m_reg[s]);
          if (total > 255) total = SAT ? 255 : total - 256;
          m_reg[0] = 8'(total);
        end
        2'd2: m_reg[dd] = m_reg[s];
        default: m_out = m_reg[s];
      endcase
    end
    #1;
    cmp("out_model", Out, m_out);
  endtask

  function automatic void add_v(input logic r, input logic [7:0] ins, input logic [7:0] d,
                                input logic chk, input logic [7:0] e);
    vec_t v;
    v.rst = r; v.instr = ins; v.din = d; v.chk = chk; v.exp_out = e;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; instr = 8'h00; din = 8'h00;
    for (int i = 0; i < 8; i++) m_reg[i] = 8'd0;
    m_out = 8'd0;

    // Reset held two cycles with an IN in flight.
    add_v(1, 8'h10, 8'hAA, 1, 8'd0);
    add_v(1, 8'h10, 8'hAA, 1, 8'd0);
    for (int r = 0; r < 8; r++) add_v(0, 8'hC0 | 8'(r), 8'h00, 1, 8'd0);
    // Load A..H and read each back.
    for (int r = 0; r < 8; r++) add_v(0, 8'(r << 3), 8'(20 + 10 * r), 0, 8'd0);
    for (int r = 0; r < 8; r++) add_v(0, 8'hC0 | 8'(r), 8'h00, 1, 8'(20 + 10 * r));
    // ADD / MOV / OUT sequence.
    add_v(0, 8'h41, 8'h00, 1, 8'd90);
    add_v(0, 8'h43, 8'h00, 1, 8'd90);
    add_v(0, 8'h8F, 8'h00, 1, 8'd90);
    add_v(0, 8'hC1, 8'h00, 1, 8'd90);
    add_v(0, 8'hC0, 8'h00, 1, 8'd100);
    add_v(0, 8'hC5, 8'h00, 1, 8'd70);
    add_v(0, 8'hC3, 8'h00, 1, 8'd50);
    // Chain with ADD A,A and ignored bits 5:3.
    add_v(0, 8'h00, 8'd10, 1, 8'd50);
    add_v(0, 8'h88, 8'h00, 0, 8'd0);
    add_v(0, 8'h40, 8'h00, 0, 8'd0);
    add_v(0, 8'h41, 8'h00, 0, 8'd0);
    add_v(0, 8'hC0, 8'h00, 1, 8'd30);
    add_v(0, 8'h40, 8'h00, 0, 8'd0);
    add_v(0, 8'hC0, 8'h00, 1, 8'd60);
    add_v(0, 8'h58, 8'h00, 0, 8'd0);
    add_v(0, 8'hC0, 8'h00, 1, 8'd120);
    add_v(0, 8'h10, 8'd33, 1, 8'd120);
    add_v(0, 8'hC2, 8'h00, 1, 8'd33);
    // Overflow.
    add_v(0, 8'h00, 8'd200, 0, 8'd0);
    add_v(0, 8'h08, 8'd100, 0, 8'd0);
    add_v(0, 8'h41, 8'h00, 0, 8'd0);
    add_v(0, 8'hC0, 8'h00, 1, SAT ? 8'd255 : 8'd44);
    // Reset during an ADD discards it and clears everything.
    add_v(0, 8'h00, 8'd7, 0, 8'd0);
    add_v(0, 8'h08, 8'd5, 0, 8'd0);
    add_v(1, 8'h41, 8'h00, 1, 8'd0);
    add_v(0, 8'hC0, 8'h00, 1, 8'd0);
    add_v(0, 8'hC1, 8'h00, 1, 8'd0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].instr, tbl[i].din);
      if (tbl[i].chk) cmp($sformatf("tbl_out[%0d]", i), Out, tbl[i].exp_out);
    end

    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 31) == 0, 8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
